imem_line_responder: RTL and testbench
======================================

// Module: imem_line_responder
// PURPOSE
//  Responder end of the fetch instruction-memory interface. Accepts fetch's imem_addr/imem_read/input_valid.
//  Returns imem_rdata/imem_raddr/imem_resp and raises imem_stall while a miss is serviced.
//  Holds one cache line in a line buffer. Misses refill the line from backing memory as a BEATS-beat burst.
// PARAMETERS
//  LINE_BYTES  32  bytes per line; power of 2, >= BEAT_BITS/8
//  BEAT_BITS   64  backing-memory data beat width; BEATS = LINE_BYTES*8/BEAT_BITS
// PORTS
//  clk          in   1          clock
//  rst_n        in   1          reset; one clock; reset is asynchronous and active-low
//  imem_addr    in   32         fetch PC; bits [1:0] ignored
//  imem_read    in   1          fetch read request
//  input_valid  in   1          0 = scheduler owns fetch; request ignored
//  flush        in   1          fetch redirect; kills in-flight response
//  imem_rdata   out  32         instruction word
//  imem_raddr   out  32         word-aligned address of imem_rdata; 0 when imem_resp=0
//  imem_resp    out  1          imem_rdata/imem_raddr valid this cycle
//  imem_stall   out  1          request not serviceable this cycle
//  bmem_addr    out  32         line-aligned refill address
//  bmem_read    out  1          refill request, held until bmem_ready
//  bmem_ready   in   1          memory accepts request this cycle
//  bmem_rdata   in   BEAT_BITS  refill beat, ascending address order
//  bmem_rvalid  in   1          beat valid
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; line valid=0; beat counter=0.
//   - All outputs 0 immediately.
//  req = imem_read & input_valid.
//  hit = line valid & tag == imem_addr[31:log2(LINE_BYTES)].
//  IDLE:
//   - req & hit: next cycle imem_resp=1, imem_rdata=selected word, imem_raddr={imem_addr[31:2],2'b0}.
//     Response is registered: 1-cycle latency, one response per cycle back-to-back.
//   - req & !hit: imem_stall=1 combinationally this cycle; go to REQ.
//   - !req: imem_resp=0 next cycle.
//  REQ:
//   - bmem_read=1, bmem_addr = line-aligned address of the missing line.
//   - bmem_ready: go to FILL; counter=0.
//   - flush while still in REQ, before bmem_ready: drop bmem_read next cycle; go to IDLE.
//  FILL:
//   - Each bmem_rvalid writes beat[counter] into the buffer; counter++.
//   - Last beat (counter==BEATS-1): set tag, line valid=1, go to IDLE.
//   - Line valid=0 from REQ entry until the last beat.
//   - The request is re-evaluated in IDLE against the current imem_addr (hit next cycle).
//   - flush in FILL: the burst still completes; all beats consumed; line validated.
//     No response for the pre-flush address.
//  imem_stall = (state!=IDLE) | (req & !hit).
//  imem_resp is never 1 while state!=IDLE.
//  flush at cycle t forces imem_resp=0 and imem_raddr=0 at t+1.
//  bmem_rvalid outside FILL is ignored; BEATS counter wraps only via the IDLE transition.
//  Word select = imem_addr[log2(LINE_BYTES)-1:2]; beats are packed little-endian (word 0 in beat 0 low bits).
// TESTING
//  1. Reset, read 0x1ECEB000 -> stall=1 same cycle; bmem_read=1, addr=0x1ECEB000.
//     Ready, 4 beats, last at cycle N -> resp=1 at N+2, raddr=0x1ECEB000.
//  2. Line resident; reads 0x1ECEB004..0x1ECEB01C back-to-back -> resp every cycle, stall=0, raddr tracks +4.
//  3. Read 0x1ECEB020 -> miss; refill replaces line; later 0x1ECEB000 misses again.
//  4. Miss, flush before bmem_ready -> bmem_read=0 next cycle, state IDLE, no resp.
//  5. Flush after beat 2 of 4, PC redirected to 0x1ECEB040 -> beats 3-4 consumed, no resp for old PC,
//     then miss on 0x1ECEB040.
//  6. input_valid=0 with imem_read=1 -> no resp, no bmem_read; rst_n low mid-FILL -> all outputs 0 with no clock edge.

Source files
------------

// File: rtl/imem_line_responder_if.sv
// Fetch-side and backing-memory-side signals of the instruction-memory line responder.
interface imem_line_responder_if #(
    parameter int BEAT_BITS = 64
);
    logic [31:0]          imem_addr;
    logic                 imem_read;
    logic                 input_valid;
    logic                 flush;
    logic [31:0]          imem_rdata;
    logic [31:0]          imem_raddr;
    logic                 imem_resp;
    logic                 imem_stall;
    logic [31:0]          bmem_addr;
    logic                 bmem_read;
    logic                 bmem_ready;
    logic [BEAT_BITS-1:0] bmem_rdata;
    logic                 bmem_rvalid;

    // Responder side: the line buffer block itself.
    modport slave (
        input  imem_addr, imem_read, input_valid, flush,
        input  bmem_ready, bmem_rdata, bmem_rvalid,
        output imem_rdata, imem_raddr, imem_resp, imem_stall,
        output bmem_addr, bmem_read
    );

    // Requester side: fetch stage plus backing memory.
    modport master (
        output imem_addr, imem_read, input_valid, flush,
        output bmem_ready, bmem_rdata, bmem_rvalid,
        input  imem_rdata, imem_raddr, imem_resp, imem_stall,
        input  bmem_addr, bmem_read
    );
endinterface

// File: rtl/imem_line_responder.sv
// Single-line instruction buffer answering fetch requests; misses refill the
// whole line from backing memory as a burst of BEATS beats.
module imem_line_responder #(
    parameter int LINE_BYTES = 32,
    parameter int BEAT_BITS  = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imem_line_responder_if.slave bus
);
    localparam int BEATS = LINE_BYTES * 8 / BEAT_BITS;
    localparam int WORDS = LINE_BYTES / 4;
    localparam int OFFS  = $clog2(LINE_BYTES);
    localparam int TAG_W = 32 - OFFS;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t                              state_q, state_d;
    logic [BEATS-1:0][BEAT_BITS-1:0]     line_q;
    logic [WORDS-1:0][31:0]              line_words;
    logic [TAG_W-1:0]                    tag_q, miss_tag_q;
    logic                                valid_q;
    logic [CNT_W-1:0]                    cnt_q;
    logic                                resp_q;
    logic [31:0]                         rdata_q, raddr_q;
    logic                                req, hit, last_beat, serve;
    logic [OFFS-3:0]                     wsel;
    logic                                unused_addr_lsbs;

    // Beats are packed low-first, so the flat line view puts word 0 in beat 0 low bits.
    assign line_words = line_q;

    assign req       = bus.imem_read & bus.input_valid;
    assign hit       = valid_q & (tag_q == bus.imem_addr[31:OFFS]);
    assign wsel      = bus.imem_addr[OFFS-1:2];
    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
    assign serve     = (state_q == IDLE) & req & hit & ~bus.flush;
    assign unused_addr_lsbs = ^bus.imem_addr[1:0];

    // Stall is gated by reset so every output reads 0 while rst_n is low.
    assign bus.imem_stall = rst_n & ((state_q != IDLE) | (req & ~hit));
    assign bus.bmem_read  = (state_q == REQ);
    assign bus.bmem_addr  = (state_q == REQ) ? {miss_tag_q, {OFFS{1'b0}}} : 32'h0;
    assign bus.imem_resp  = resp_q;
    assign bus.imem_rdata = rdata_q;
    assign bus.imem_raddr = raddr_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: a granted refill always runs to completion, flush only aborts before the grant.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req && !hit) state_d = REQ;
            REQ:     if (bus.bmem_ready) state_d = FILL;
                     else if (bus.flush) state_d = IDLE;
            FILL:    if (bus.bmem_rvalid && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Line buffer, tag and beat counter; the line is invalid from miss until the last beat lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q     <= '0;
            tag_q      <= '0;
            miss_tag_q <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (state_q == IDLE && req && !hit) begin
                miss_tag_q <= bus.imem_addr[31:OFFS];
                valid_q    <= 1'b0;
            end
            if (state_q == REQ && bus.bmem_ready) cnt_q <= '0;
            if (state_q == FILL && bus.bmem_rvalid) begin
                line_q[cnt_q] <= bus.bmem_rdata;
                if (last_beat) begin
                    tag_q   <= miss_tag_q;
                    valid_q <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    cnt_q   <= cnt_q + 1'b1;
                end
            end
        end
    end

    // Registered hit response; address and data read zero on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q  <= 1'b0;
            rdata_q <= '0;
            raddr_q <= '0;
        end else begin
            resp_q  <= serve;
            rdata_q <= serve ? line_words[wsel] : 32'h0;
            raddr_q <= serve ? {bus.imem_addr[31:2], 2'b00} : 32'h0;
        end
    end
endmodule

// File: tb/tb_imem_line_responder.sv
// Randomized scoreboard bench for imem_line_responder with a word-addressed memory model.
module tb_imem_line_responder;
    localparam int LB    = 32;
    localparam int BB    = 64;
    localparam int BEATS = LB * 8 / BB;
    localparam int WPB   = BB / 32;
    localparam int OFFS  = $clog2(LB);
    localparam int TW    = 32 - OFFS;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    imem_line_responder_if #(.BEAT_BITS(BB)) bus();

    imem_line_responder #(.LINE_BYTES(LB), .BEAT_BITS(BB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        int          due;
        logic [31:0] raddr;
        logic [31:0] rdata;
    } exp_t;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    exp_t sbq[$];

    // Reference model: which line is resident and where the refill is.
    int          phase = 0;          // 0 idle, 1 requesting, 2 filling
    bit          res_valid = 0;
    logic [TW-1:0] res_line = '0;
    logic [TW-1:0] miss_line = '0;
    bit          hold = 0;
    bit          in_rst = 1;
    bit          exp_stall = 0;
    int          beats = 0;
    bit          rdy_q = 0, rv_q = 0;
    int          delay = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E3779B1) ^ 32'hC3A50F1E ^ (w >> 7);
    endfunction

    function automatic logic [BB-1:0] beat_data(input logic [TW-1:0] line, input int b);
        logic [BB-1:0] d;
        logic [31:0]   base;
        base = {line, {OFFS{1'b0}}};
        for (int k = 0; k < WPB; k++) d[k*32 +: 32] = mem_word(base + 32'(b * WPB * 4 + k * 4));
        return d;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        compared++;
        mismatched++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // Monitor: stall every cycle, responses popped against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!in_rst) begin
            check("stall", bus.imem_stall, exp_stall);
            if (bus.imem_resp) begin
                if (sbq.size() == 0) begin
                    fail_now("unexpected_resp", $sformatf("raddr %0h with nothing expected", bus.imem_raddr));
                end else begin
                    e = sbq.pop_front();
                    check("resp_cycle", cyc, e.due);
                    check("raddr", bus.imem_raddr, e.raddr);
                    check("rdata", bus.imem_rdata, e.rdata);
                end
            end else begin
                check("raddr_idle", bus.imem_raddr, 0);
                if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    fail_now("missing_resp", $sformatf("no response for %0h", sbq[0].raddr));
                    void'(sbq.pop_front());
                end
            end
        end
    end

    // Backing memory: grants after a random delay, then streams beats with random gaps.
    initial begin
        bus.bmem_ready = 1'b0; bus.bmem_rvalid = 1'b0; bus.bmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (in_rst) begin
                bus.bmem_ready = 1'b0; bus.bmem_rvalid = 1'b0;
                rdy_q = 0; rv_q = 0;
                continue;
            end
            if (rdy_q) begin phase = 2; beats = 0; end
            if (rv_q && phase == 2) begin
                beats++;
                if (beats == BEATS) begin res_valid = 1; res_line = miss_line; phase = 0; end
            end
            rdy_q = 0; rv_q = 0;
            bus.bmem_ready = 1'b0; bus.bmem_rvalid = 1'b0; bus.bmem_rdata = {$urandom, $urandom};
            check("bmem_read", bus.bmem_read, (phase == 1));
            if (phase == 1) begin
                check("bmem_addr", bus.bmem_addr, {miss_line, {OFFS{1'b0}}});
                if (!hold) begin
                    if (delay == 0) begin
                        bus.bmem_ready = 1'b1; rdy_q = 1; delay = $urandom_range(0, 3);
                    end else delay--;
                end
            end else if (phase == 2) begin
                if ($urandom_range(0, 3) != 0) begin
                    bus.bmem_rvalid = 1'b1; bus.bmem_rdata = beat_data(miss_line, beats); rv_q = 1;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                bus.bmem_rvalid = 1'b1;   // stray beat outside a refill must be ignored
            end
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    // Drive one fetch cycle and predict its stall and response.
    task automatic drive(input logic [31:0] a, input bit rd, input bit iv, input bit fl, output bit pushed);
        bit req, hit;
        int ph0;
        ph0 = phase;
        bus.imem_addr = a; bus.imem_read = rd; bus.input_valid = iv; bus.flush = fl;
        req = rd && iv;
        hit = res_valid && (res_line == a[31:OFFS]);
        pushed = 0;
        if (ph0 != 0) exp_stall = 1;
        else if (req && !hit) begin
            exp_stall = 1; phase = 1; miss_line = a[31:OFFS]; res_valid = 0;
        end else begin
            exp_stall = 0;
            if (req && hit && !fl) begin
                sbq.push_back('{cyc + 1, {a[31:2], 2'b00}, mem_word(a)});
                pushed = 1;
            end
        end
        if (ph0 == 1 && fl) phase = 0;
    endtask

    task automatic idle(input int n);
        bit p;
        for (int i = 0; i < n; i++) begin drive(32'h0, 0, 1, 0, p); step(); end
    endtask

    task automatic fetch(input logic [31:0] a);
        bit got;
        int n;
        got = 0; n = 0;
        while (!got && n < 200) begin drive(a, 1, 1, 0, got); step(); n++; end
        if (!got) fail_now("fetch_timeout", $sformatf("addr %0h never served", a));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_resp"},  bus.imem_resp, 0);
        check({tag, "_rdata"}, bus.imem_rdata, 0);
        check({tag, "_raddr"}, bus.imem_raddr, 0);
        check({tag, "_stall"}, bus.imem_stall, 0);
        check({tag, "_bread"}, bus.bmem_read, 0);
        check({tag, "_baddr"}, bus.bmem_addr, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit p;
        int n;
        logic [31:0] a;
        bit rd, iv, fl, req, hit;

        bus.imem_addr = 32'h1ECEB000; bus.imem_read = 1'b1; bus.input_valid = 1'b1; bus.flush = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step(); in_rst = 0;

        // Cold miss, refill, then back-to-back hits across the line.
        fetch(32'h1ECEB000);
        for (int w = 1; w < 8; w++) fetch(32'h1ECEB000 + 32'(w * 4));
        idle(2);

        // Neighbouring line replaces the buffer; the first line then misses again.
        fetch(32'h1ECEB020);
        fetch(32'h1ECEB000);
        idle(1);

        // Flush while the refill is still ungranted.
        hold = 1;
        drive(32'h1ECEB040, 1, 1, 0, p); step();
        drive(32'h1ECEB040, 1, 1, 1, p); step();
        hold = 0;
        idle(3);

        // Flush after two beats with a redirect: burst completes, new PC misses.
        n = 0;
        while (!(phase == 2 && beats >= 2) && n < 100) begin drive(32'h1ECEB060, 1, 1, 0, p); step(); n++; end
        if (n >= 100) fail_now("fill_wait", "refill never reached beat 2");
        drive(32'h1ECEB040, 1, 1, 1, p); step();
        fetch(32'h1ECEB040);
        idle(1);

        // Scheduler owns fetch: no response, no refill.
        for (int i = 0; i < 4; i++) begin drive(32'h1ECEB080, 1, 0, 0, p); step(); end

        // Asynchronous reset in the middle of a refill.
        n = 0;
        while (phase != 2 && n < 100) begin drive(32'h1ECEB0A0, 1, 1, 0, p); step(); n++; end
        if (n >= 100) fail_now("fill_wait2", "refill never started");
        #1 rst_n = 1'b0; in_rst = 1;
        #1 check_all_zero("midfill_reset");
        phase = 0; res_valid = 0; beats = 0; sbq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step(); in_rst = 0;
        fetch(32'h1ECEB0A4);

        // Random traffic over four lines.
        for (int i = 0; i < 400; i++) begin
            a  = 32'h1ECEB000 + 32'($urandom_range(0, 3) * 32) + 32'($urandom_range(0, 7) * 4);
            rd = ($urandom_range(0, 9) < 8);
            iv = ($urandom_range(0, 9) < 9);
            fl = ($urandom_range(0, 9) == 0);
            req = rd && iv;
            hit = res_valid && (res_line == a[31:OFFS]);
            if (phase == 1 || (phase == 0 && req && !hit)) fl = 0;
            drive(a, rd, iv, fl, p); step();
        end

        n = 0;
        while ((phase != 0 || sbq.size() != 0) && n < 200) begin idle(1); n++; end
        idle(2);
        check("scoreboard_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
